// File: rtl/vector_sequencer.sv
// rtl/vector_sequencer.sv - BRAM read initiator that streams template/FF configs and input vectors downstream
module vector_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [CNT_W-1:0]   VECTOR_COUNT,
    input  logic               BRAM_READY,
    output logic               BRAM_INPUT_READ,
    output logic               BRAM_TEMPLATE_READ,
    output logic               BRAM_FF_READ,
    output logic [1:0]         BRAM_TEMPLATE_BITS,
    input  logic [127:0]       BRAM_READ_DATA_0,
    input  logic [127:0]       BRAM_READ_DATA_1,
    input  logic               BRAM_TEMPLATE_CHANGE,
    output logic               CFG_VALID,
    input  logic               CFG_READY,
    output logic [125:0]       CFG_TEMPLATE,
    output logic [251:0]       CFG_FF,
    output logic               VEC_VALID,
    input  logic               VEC_READY,
    output logic [125:0]       VEC_DATA,
    output logic               BUSY,
    output logic               DONE,
    output logic [CNT_W-1:0]   VEC_APPLIED,
    output logic               TEMPLATE_ERR
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_INPUT,
        S_WAIT_INPUT,
        S_RD_TEMPLATE,
        S_WAIT_TEMPLATE,
        S_RD_FF,
        S_WAIT_FF,
        S_SEND_CFG,
        S_SEND_VEC,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   vec_applied_q, vec_applied_d;
    logic               template_err_q, template_err_d;
    logic               first_vec_q, first_vec_d;
    // Set on the cycle a read is issued so the first WAIT cycle ignores BRAM_READY,
    // which may still show the controller's pre-read idle level.
    logic               blank_q, blank_d;
    logic [1:0]         tbits_q, tbits_d;
    logic [125:0]       vec_data_q, vec_data_d;
    logic [125:0]       cfg_template_q, cfg_template_d;
    logic [251:0]       cfg_ff_q, cfg_ff_d;

    // Top bits of word 1 carry nothing for FF reads.
    logic               unused_data1_bits;
    assign unused_data1_bits = ^BRAM_READ_DATA_1[127:126];

    // State and datapath registers; reset returns every output to its idle value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            vec_applied_q  <= '0;
            template_err_q <= 1'b0;
            first_vec_q    <= 1'b0;
            blank_q        <= 1'b0;
            tbits_q        <= 2'b00;
            vec_data_q     <= '0;
            cfg_template_q <= '0;
            cfg_ff_q       <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            vec_applied_q  <= vec_applied_d;
            template_err_q <= template_err_d;
            first_vec_q    <= first_vec_d;
            blank_q        <= blank_d;
            tbits_q        <= tbits_d;
            vec_data_q     <= vec_data_d;
            cfg_template_q <= cfg_template_d;
            cfg_ff_q       <= cfg_ff_d;
        end
    end

    // Next-state logic, read strobes and data capture for the fetch/deliver sequence.
    always_comb begin
        state_d            = state_q;
        count_d            = count_q;
        vec_applied_d      = vec_applied_q;
        template_err_d     = template_err_q;
        first_vec_d        = first_vec_q;
        blank_d            = blank_q;
        tbits_d            = tbits_q;
        vec_data_d         = vec_data_q;
        cfg_template_d     = cfg_template_q;
        cfg_ff_d           = cfg_ff_q;
        BRAM_INPUT_READ    = 1'b0;
        BRAM_TEMPLATE_READ = 1'b0;
        BRAM_FF_READ       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (VECTOR_COUNT == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        count_d        = VECTOR_COUNT;
                        vec_applied_d  = '0;
                        template_err_d = 1'b0;
                        first_vec_d    = 1'b1;
                        state_d        = S_RD_INPUT;
                    end
                end
            end

            S_RD_INPUT: begin
                if (BRAM_READY) begin
                    BRAM_INPUT_READ = 1'b1;
                    blank_d         = 1'b1;
                    state_d         = S_WAIT_INPUT;
                end
            end

            S_WAIT_INPUT: begin
                if (blank_q) begin
                    blank_d = 1'b0;
                end else if (BRAM_READY) begin
                    vec_data_d = BRAM_READ_DATA_0[125:0];
                    tbits_d    = BRAM_READ_DATA_0[127:126];
                    // The first vector of a run always needs a config, even if the
                    // controller reports no change relative to a previous run.
                    if (BRAM_TEMPLATE_CHANGE || first_vec_q) begin
                        state_d = S_RD_TEMPLATE;
                    end else begin
                        state_d = S_SEND_VEC;
                    end
                end
            end

            S_RD_TEMPLATE: begin
                if (BRAM_READY) begin
                    BRAM_TEMPLATE_READ = 1'b1;
                    blank_d            = 1'b1;
                    state_d            = S_WAIT_TEMPLATE;
                end
            end

            S_WAIT_TEMPLATE: begin
                if (blank_q) begin
                    blank_d = 1'b0;
                end else if (BRAM_READY) begin
                    cfg_template_d = BRAM_READ_DATA_0[125:0];
                    if (BRAM_READ_DATA_0[127:126] != tbits_q) begin
                        template_err_d = 1'b1;
                    end
                    state_d = S_RD_FF;
                end
            end

            S_RD_FF: begin
                if (BRAM_READY) begin
                    BRAM_FF_READ = 1'b1;
                    blank_d      = 1'b1;
                    state_d      = S_WAIT_FF;
                end
            end

            S_WAIT_FF: begin
                if (blank_q) begin
                    blank_d = 1'b0;
                end else if (BRAM_READY) begin
                    cfg_ff_d    = {BRAM_READ_DATA_1[125:0], BRAM_READ_DATA_0[125:0]};
                    first_vec_d = 1'b0;
                    state_d     = S_SEND_CFG;
                end
            end

            S_SEND_CFG: begin
                if (CFG_READY) begin
                    state_d = S_SEND_VEC;
                end
            end

            S_SEND_VEC: begin
                if (VEC_READY) begin
                    vec_applied_d = vec_applied_q + 1'b1;
                    if (vec_applied_d == count_q) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_RD_INPUT;
                    end
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign BRAM_TEMPLATE_BITS = tbits_q;
    assign CFG_VALID          = (state_q == S_SEND_CFG);
    assign CFG_TEMPLATE       = cfg_template_q;
    assign CFG_FF             = cfg_ff_q;
    assign VEC_VALID          = (state_q == S_SEND_VEC);
    assign VEC_DATA           = vec_data_q;
    assign BUSY               = (state_q != S_IDLE);
    assign DONE               = (state_q == S_FINISH);
    assign VEC_APPLIED        = vec_applied_q;
    assign TEMPLATE_ERR       = template_err_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// tb/tb_vector_sequencer.sv - scoreboard bench for vector_sequencer with a behavioural BRAM responder
module tb_vector_sequencer;

    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               RST;
    logic               START;
    logic [CNT_W-1:0]   VECTOR_COUNT;
    logic               BRAM_READY;
    logic               BRAM_INPUT_READ;
    logic               BRAM_TEMPLATE_READ;
    logic               BRAM_FF_READ;
    logic [1:0]         BRAM_TEMPLATE_BITS;
    logic [127:0]       BRAM_READ_DATA_0;
    logic [127:0]       BRAM_READ_DATA_1;
    logic               BRAM_TEMPLATE_CHANGE;
    logic               CFG_VALID;
    logic               CFG_READY;
    logic [125:0]       CFG_TEMPLATE;
    logic [251:0]       CFG_FF;
    logic               VEC_VALID;
    logic               VEC_READY;
    logic [125:0]       VEC_DATA;
    logic               BUSY;
    logic               DONE;
    logic [CNT_W-1:0]   VEC_APPLIED;
    logic               TEMPLATE_ERR;

    always #5 clk = ~clk;

    vector_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK                  (clk),
        .RST                  (RST),
        .START                (START),
        .VECTOR_COUNT         (VECTOR_COUNT),
        .BRAM_READY           (BRAM_READY),
        .BRAM_INPUT_READ      (BRAM_INPUT_READ),
        .BRAM_TEMPLATE_READ   (BRAM_TEMPLATE_READ),
        .BRAM_FF_READ         (BRAM_FF_READ),
        .BRAM_TEMPLATE_BITS   (BRAM_TEMPLATE_BITS),
        .BRAM_READ_DATA_0     (BRAM_READ_DATA_0),
        .BRAM_READ_DATA_1     (BRAM_READ_DATA_1),
        .BRAM_TEMPLATE_CHANGE (BRAM_TEMPLATE_CHANGE),
        .CFG_VALID            (CFG_VALID),
        .CFG_READY            (CFG_READY),
        .CFG_TEMPLATE         (CFG_TEMPLATE),
        .CFG_FF               (CFG_FF),
        .VEC_VALID            (VEC_VALID),
        .VEC_READY            (VEC_READY),
        .VEC_DATA             (VEC_DATA),
        .BUSY                 (BUSY),
        .DONE                 (DONE),
        .VEC_APPLIED          (VEC_APPLIED),
        .TEMPLATE_ERR         (TEMPLATE_ERR)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // BRAM contents
    logic [125:0] vdata [0:15];
    logic [1:0]   vtmpl [0:15];
    logic [125:0] tcfg  [0:3];
    logic [127:0] ffw0  [0:3];
    logic [127:0] ffw1  [0:3];
    logic         corrupt  = 1'b0;

    // responder / monitor state
    int           rd_idx    = 0;
    int           lat       = 0;
    logic [1:0]   cur_tmpl  = 2'b00;
    logic [1:0]   prev_tmpl = 2'b00;
    int           in_reads  = 0;
    int           tm_reads  = 0;
    int           ff_reads  = 0;
    int           done_cnt  = 0;
    int           cfg_stall = 0;
    int           cfg_wait  = 0;
    logic         vec_rand  = 1'b0;
    logic         cfg_pend  = 1'b0;
    logic         vec_pend  = 1'b0;
    logic [125:0] held_tmpl;
    logic [251:0] held_ff;
    logic [125:0] held_vec;

    typedef struct packed {
        logic [125:0] tmpl;
        logic [251:0] ff;
    } cfg_t;

    cfg_t         exp_cfg_q [$];
    logic [125:0] exp_vec_q [$];

    function automatic logic [125:0] rand126();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[125:0];
    endfunction

    // BRAM responder and downstream sink, acting on the falling edge
    initial begin : responder
        cfg_t         e;
        logic [125:0] v;
        BRAM_READY           = 1'b1;
        BRAM_READ_DATA_0     = '0;
        BRAM_READ_DATA_1     = '0;
        BRAM_TEMPLATE_CHANGE = 1'b0;
        CFG_READY            = 1'b0;
        VEC_READY            = 1'b0;
        forever begin
            @(negedge clk);
            if (RST) begin
                BRAM_READY = 1'b1;
                lat        = 0;
                rd_idx     = 0;
                cfg_pend   = 1'b0;
                vec_pend   = 1'b0;
                cfg_wait   = 0;
                CFG_READY  = 1'b0;
                VEC_READY  = 1'b0;
            end else begin
                if (DONE) begin
                    done_cnt++;
                    rd_idx = 0;
                end
                if (BRAM_INPUT_READ || BRAM_TEMPLATE_READ || BRAM_FF_READ) begin
                    check_eq("strobe_with_ready", BRAM_READY, 1);
                    check_eq("single_strobe", $countones({BRAM_INPUT_READ, BRAM_TEMPLATE_READ, BRAM_FF_READ}), 1);
                    if (BRAM_INPUT_READ) begin
                        in_reads++;
                        if (rd_idx < 16) begin
                            cur_tmpl             = vtmpl[rd_idx];
                            BRAM_READ_DATA_0     = {vtmpl[rd_idx], vdata[rd_idx]};
                            BRAM_TEMPLATE_CHANGE = (rd_idx == 0) || (vtmpl[rd_idx] != prev_tmpl);
                            prev_tmpl            = vtmpl[rd_idx];
                            rd_idx++;
                        end
                    end
                    if (BRAM_TEMPLATE_READ) begin
                        tm_reads++;
                        check_eq("tbits_at_tmpl_read", BRAM_TEMPLATE_BITS, cur_tmpl);
                        BRAM_READ_DATA_0 = {(corrupt ? (BRAM_TEMPLATE_BITS ^ 2'b11) : BRAM_TEMPLATE_BITS),
                                            tcfg[BRAM_TEMPLATE_BITS]};
                    end
                    if (BRAM_FF_READ) begin
                        ff_reads++;
                        check_eq("tbits_at_ff_read", BRAM_TEMPLATE_BITS, cur_tmpl);
                        BRAM_READ_DATA_0 = ffw0[BRAM_TEMPLATE_BITS];
                        BRAM_READ_DATA_1 = ffw1[BRAM_TEMPLATE_BITS];
                    end
                    lat        = $urandom_range(0, 3);
                    BRAM_READY = (lat == 0);
                end else if (lat > 0) begin
                    lat--;
                    if (lat == 0) BRAM_READY = 1'b1;
                end

                // config channel
                if (cfg_pend) begin
                    check_eq("cfg_valid_held", CFG_VALID, 1);
                    check_eq("cfg_tmpl_stable", CFG_TEMPLATE, held_tmpl);
                    check_eq("cfg_ff_stable", CFG_FF, held_ff);
                end
                if (CFG_VALID) begin
                    CFG_READY = (cfg_wait >= cfg_stall);
                    cfg_wait++;
                    if (CFG_READY) begin
                        if (exp_cfg_q.size() == 0) begin
                            check_eq("cfg_unexpected", 1, 0);
                        end else begin
                            e = exp_cfg_q.pop_front();
                            check_eq("cfg_template", CFG_TEMPLATE, e.tmpl);
                            check_eq("cfg_ff", CFG_FF, e.ff);
                        end
                        cfg_pend = 1'b0;
                    end else begin
                        cfg_pend  = 1'b1;
                        held_tmpl = CFG_TEMPLATE;
                        held_ff   = CFG_FF;
                    end
                end else begin
                    CFG_READY = 1'b0;
                    cfg_wait  = 0;
                end

                // vector channel
                if (vec_pend) begin
                    check_eq("vec_valid_held", VEC_VALID, 1);
                    check_eq("vec_data_stable", VEC_DATA, held_vec);
                end
                if (VEC_VALID) begin
                    VEC_READY = vec_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (VEC_READY) begin
                        if (exp_vec_q.size() == 0) begin
                            check_eq("vec_unexpected", 1, 0);
                        end else begin
                            v = exp_vec_q.pop_front();
                            check_eq("vec_data", VEC_DATA, v);
                        end
                        vec_pend = 1'b0;
                    end else begin
                        vec_pend = 1'b1;
                        held_vec = VEC_DATA;
                    end
                end else begin
                    VEC_READY = 1'b0;
                end
            end
        end
    end

    task automatic load_expect(input int n, output int loads);
        cfg_t e;
        loads = 0;
        for (int i = 0; i < n; i++) begin
            if (i == 0 || vtmpl[i] != vtmpl[i-1]) begin
                loads++;
                e.tmpl = tcfg[vtmpl[i]];
                e.ff   = {ffw1[vtmpl[i]][125:0], ffw0[vtmpl[i]][125:0]};
                exp_cfg_q.push_back(e);
            end
            exp_vec_q.push_back(vdata[i]);
        end
    endtask

    task automatic pulse_start(input int n);
        START        = 1'b1;
        VECTOR_COUNT = n[CNT_W-1:0];
        @(negedge clk); #1;
        START        = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int n, input int loads, input logic exp_err,
                              input int in0, input int tm0, input int ff0, input int d0);
        int budget;
        budget = 3000;
        while (done_cnt == d0 && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        check_eq({tag, "_no_timeout"}, (budget > 0), 1);
        repeat (3) begin @(negedge clk); #1; end
        check_eq({tag, "_done_pulses"}, done_cnt - d0, 1);
        check_eq({tag, "_vec_applied"}, VEC_APPLIED, n);
        check_eq({tag, "_input_reads"}, in_reads - in0, n);
        check_eq({tag, "_tmpl_reads"}, tm_reads - tm0, loads);
        check_eq({tag, "_ff_reads"}, ff_reads - ff0, loads);
        check_eq({tag, "_cfg_left"}, exp_cfg_q.size(), 0);
        check_eq({tag, "_vec_left"}, exp_vec_q.size(), 0);
        check_eq({tag, "_template_err"}, TEMPLATE_ERR, exp_err);
        check_eq({tag, "_busy_after"}, BUSY, 0);
        exp_cfg_q.delete();
        exp_vec_q.delete();
    endtask

    task automatic run_vectors(input string tag, input int n, input logic exp_err);
        int loads, in0, tm0, ff0, d0;
        load_expect(n, loads);
        in0 = in_reads; tm0 = tm_reads; ff0 = ff_reads; d0 = done_cnt;
        pulse_start(n);
        check_eq({tag, "_busy_start"}, BUSY, 1);
        check_eq({tag, "_err_cleared"}, TEMPLATE_ERR, 0);
        finish_run(tag, n, loads, exp_err, in0, tm0, ff0, d0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ctrl"}, {BRAM_INPUT_READ, BRAM_TEMPLATE_READ, BRAM_FF_READ, CFG_VALID,
                                  VEC_VALID, BUSY, DONE, TEMPLATE_ERR, BRAM_TEMPLATE_BITS}, 0);
        check_eq({tag, "_vec_applied"}, VEC_APPLIED, 0);
        check_eq({tag, "_cfg_template"}, CFG_TEMPLATE, 0);
        check_eq({tag, "_cfg_ff"}, CFG_FF, 0);
        check_eq({tag, "_vec_data"}, VEC_DATA, 0);
    endtask

    initial begin : main
        int loads, in0, tm0, ff0, d0, budget;
        RST          = 1'b1;
        START        = 1'b0;
        VECTOR_COUNT = '0;
        for (int t = 0; t < 4; t++) begin
            tcfg[t] = rand126();
            ffw0[t] = {$urandom, $urandom, $urandom, $urandom};
            ffw1[t] = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int i = 0; i < 16; i++) begin
            vdata[i] = rand126();
            vtmpl[i] = 2'b00;
        end
        repeat (3) begin @(negedge clk); #1; end
        check_idle_outputs("reset");
        RST = 1'b0;
        @(negedge clk); #1;

        // three vectors, one template
        for (int i = 0; i < 3; i++) begin vtmpl[i] = 2'b01; vdata[i] = rand126(); end
        run_vectors("single_tmpl", 3, 1'b0);

        // template sequence 00,00,11,11,00
        vtmpl[0] = 2'b00; vtmpl[1] = 2'b00; vtmpl[2] = 2'b11; vtmpl[3] = 2'b11; vtmpl[4] = 2'b00;
        for (int i = 0; i < 5; i++) vdata[i] = rand126();
        run_vectors("tmpl_switch", 5, 1'b0);

        // zero-length run
        in0 = in_reads; tm0 = tm_reads; ff0 = ff_reads; d0 = done_cnt;
        pulse_start(0);
        check_eq("zero_done_pulse", DONE, 1);
        check_eq("zero_busy_pulse", BUSY, 1);
        @(negedge clk); #1;
        check_eq("zero_done_end", DONE, 0);
        check_eq("zero_busy_end", BUSY, 0);
        check_eq("zero_strobes", (in_reads - in0) + (tm_reads - tm0) + (ff_reads - ff0), 0);
        check_eq("zero_done_cnt", done_cnt - d0, 1);

        // stalled config, random vector backpressure
        cfg_stall = 10;
        vec_rand  = 1'b1;
        vtmpl[0] = 2'b10; vtmpl[1] = 2'b10; vtmpl[2] = 2'b01; vtmpl[3] = 2'b01;
        for (int i = 0; i < 4; i++) vdata[i] = rand126();
        run_vectors("stall", 4, 1'b0);
        cfg_stall = 0;
        vec_rand  = 1'b0;

        // corrupted template bits
        corrupt = 1'b1;
        for (int i = 0; i < 3; i++) begin vtmpl[i] = 2'b01; vdata[i] = rand126(); end
        run_vectors("tmpl_err", 3, 1'b1);
        corrupt = 1'b0;
        vdata[0] = rand126();
        run_vectors("err_clear", 1, 1'b0);

        // START pulsed while busy is ignored
        vtmpl[0] = 2'b11; vtmpl[1] = 2'b00; vtmpl[2] = 2'b00;
        for (int i = 0; i < 3; i++) vdata[i] = rand126();
        load_expect(3, loads);
        in0 = in_reads; tm0 = tm_reads; ff0 = ff_reads; d0 = done_cnt;
        pulse_start(3);
        repeat (4) begin @(negedge clk); #1; end
        pulse_start(1);
        finish_run("busy_start", 3, loads, 1'b0, in0, tm0, ff0, d0);

        // reset while waiting on the FF read
        vtmpl[0] = 2'b10; vtmpl[1] = 2'b11;
        load_expect(2, loads);
        pulse_start(2);
        budget = 200;
        while (!BRAM_FF_READ && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        check_eq("rst_ff_read_seen", (budget > 0), 1);
        @(negedge clk); #1;
        RST = 1'b1;
        @(negedge clk); #1;
        check_idle_outputs("mid_reset");
        RST = 1'b0;
        exp_cfg_q.delete();
        exp_vec_q.delete();
        in0 = in_reads; tm0 = tm_reads; ff0 = ff_reads; d0 = done_cnt;
        repeat (6) begin @(negedge clk); #1; end
        check_eq("post_rst_strobes", (in_reads - in0) + (tm_reads - tm0) + (ff_reads - ff0), 0);
        check_eq("post_rst_busy", BUSY, 0);
        check_eq("post_rst_done", done_cnt - d0, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
